rf_wport_arbiter: RTL and testbench



---
 rtl/rf_wport_arbiter.sv | 156 +++++++++++++++
 tb/tb_rf_wport_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter
//   Shares the single register-file write port between the in-order writeback
//   stage (pipe) and a long-latency unit (lu: mul/div). lu results are queued in
//   a small FIFO. The pipe has priority. When the FIFO head has been denied
//   MAX_WAIT cycles in a row, a one-cycle pipe_stall is raised so the head drains.
//   A per-register busy scoreboard tracks lu destinations that are still in flight.
//   Decode queries it to detect hazards.
//
// Ports
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_pipe_wen/waddr/wdata            WB write request (waddr 0 is not a request)
//   i_lu_valid/lu_rd/lu_wdata         lu result; accepted when o_lu_ready
//   o_lu_ready                        FIFO has room (current occupancy only)
//   i_issue_valid/issue_rd            lu op issued; marks issue_rd busy
//   i_raddr1/2, o_busy1/2             scoreboard lookups for decode
//   o_pipe_stall                      WB must hold; its request is ignored
//   o_rf_wen/waddr/wdata              RegFile write port
//   o_fifo_count                      FIFO occupancy
module rf_wport_arbiter #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_pipe_wen,
    input  logic [4:0]               i_pipe_waddr,
    input  logic [63:0]              i_pipe_wdata,
    input  logic                     i_lu_valid,
    output logic                     o_lu_ready,
    input  logic [4:0]               i_lu_rd,
    input  logic [63:0]              i_lu_wdata,
    input  logic                     i_issue_valid,
    input  logic [4:0]               i_issue_rd,
    input  logic [4:0]               i_raddr1,
    input  logic [4:0]               i_raddr2,
    output logic                     o_busy1,
    output logic                     o_busy2,
    output logic                     o_pipe_stall,
    output logic                     o_rf_wen,
    output logic [4:0]               o_rf_waddr,
    output logic [63:0]              o_rf_wdata,
    output logic [$clog2(DEPTH):0]   o_fifo_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [WW-1:0] MAX_C   = WW'(MAX_WAIT);

    logic [4:0]    r_rd   [DEPTH];
    logic [63:0]   r_data [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [WW-1:0] r_wait;
    logic          r_stall;
    logic [31:0]   r_busy;

    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_pipe_req;
    logic          w_grant_pipe;
    logic [4:0]    w_head_rd;
    logic [63:0]   w_head_data;
    logic [WW-1:0] w_wait_d;
    logic          w_stall_d;
    logic [31:0]   w_busy_d;

    assign w_empty     = (r_count == '0);
    assign w_head_rd   = r_rd[r_rptr];
    assign w_head_data = r_data[r_rptr];
    assign o_lu_ready  = (r_count < DEPTH_C);
    assign w_push      = i_lu_valid & o_lu_ready;

    // The pipe wins unless a stall is in force; a stall always coincides with a
    // non-empty FIFO, so whenever the pipe is not granted a waiting head pops.
    assign w_pipe_req   = i_pipe_wen & (i_pipe_waddr != 5'd0);
    assign w_grant_pipe = w_pipe_req & ~r_stall;
    assign w_pop        = ~w_empty & ~w_grant_pipe;

    always_comb begin
        o_rf_wen   = 1'b0;
        o_rf_waddr = 5'd0;
        o_rf_wdata = 64'd0;
        if (w_grant_pipe) begin
            o_rf_wen   = 1'b1;
            o_rf_waddr = i_pipe_waddr;
            o_rf_wdata = i_pipe_wdata;
        end else if (w_pop && (w_head_rd != 5'd0)) begin
            // A head targeting x0 still pops, just without a write.
            o_rf_wen   = 1'b1;
            o_rf_waddr = w_head_rd;
            o_rf_wdata = w_head_data;
        end
    end

    always_comb begin
        w_wait_d = r_wait;
        if (w_empty || w_pop) begin
            w_wait_d = '0;
        end else if (r_wait != MAX_C) begin
            w_wait_d = r_wait + WW'(1);
        end
    end

    assign w_stall_d = (w_wait_d == MAX_C) & ~w_pop;

    // Clear on pop first, then set on issue, so a same-cycle set wins.
    always_comb begin
        w_busy_d = r_busy;
        if (w_pop) begin
            w_busy_d[w_head_rd] = 1'b0;
        end
        if (i_issue_valid && (i_issue_rd != 5'd0)) begin
            w_busy_d[i_issue_rd] = 1'b1;
        end
    end

    assign o_busy1      = (i_raddr1 != 5'd0) & r_busy[i_raddr1];
    assign o_busy2      = (i_raddr2 != 5'd0) & r_busy[i_raddr2];
    assign o_pipe_stall = r_stall;
    assign o_fifo_count = r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_wait  <= '0;
            r_stall <= 1'b0;
            r_busy  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            r_wait  <= w_wait_d;
            r_stall <= w_stall_d;
            r_busy  <= w_busy_d;
        end
    end

    // Storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_rd[r_wptr]   <= i_lu_rd;
            r_data[r_wptr] <= i_lu_wdata;
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb_rf_wport_arbiter
//   Directed scenarios followed by random traffic. A queue-based reference model
//   predicts every output each cycle from the arbitration rules.
module tb_rf_wport_arbiter;

    localparam int unsigned DEPTH    = 2;
    localparam int unsigned MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wen;
    logic [4:0]  pipe_waddr;
    logic [63:0] pipe_wdata;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [63:0] lu_wdata;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        busy1;
    logic        busy2;
    logic        pipe_stall;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [$clog2(DEPTH):0] fifo_count;

    always #5 clk = ~clk;

    rf_wport_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_pipe_wen   (pipe_wen),
        .i_pipe_waddr (pipe_waddr),
        .i_pipe_wdata (pipe_wdata),
        .i_lu_valid   (lu_valid),
        .o_lu_ready   (lu_ready),
        .i_lu_rd      (lu_rd),
        .i_lu_wdata   (lu_wdata),
        .i_issue_valid(issue_valid),
        .i_issue_rd   (issue_rd),
        .i_raddr1     (raddr1),
        .i_raddr2     (raddr2),
        .o_busy1      (busy1),
        .o_busy2      (busy2),
        .o_pipe_stall (pipe_stall),
        .o_rf_wen     (rf_wen),
        .o_rf_waddr   (rf_waddr),
        .o_rf_wdata   (rf_wdata),
        .o_fifo_count (fifo_count)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    ent_t        m_q[$];
    bit   [31:0] m_busy;
    int          m_wait;
    bit          m_stall;
    bit          m_known = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 0: no write, 1: pipe, 2: FIFO head
    function automatic int m_grant();
        bit preq;
        preq = pipe_wen && (pipe_waddr != 5'd0);
        if (m_stall && m_q.size() > 0) return 2;
        if (preq && !m_stall) return 1;
        if (m_q.size() > 0) return 2;
        return 0;
    endfunction

    function automatic bit m_busy_rd(input logic [4:0] a);
        return (a != 5'd0) ? m_busy[a] : 1'b0;
    endfunction

    task automatic clr();
        rst = 0; pipe_wen = 0; pipe_waddr = 0; pipe_wdata = 0;
        lu_valid = 0; lu_rd = 0; lu_wdata = 0;
        issue_valid = 0; issue_rd = 0; raddr1 = 0; raddr2 = 0;
    endtask

    // Called at a negedge after inputs are set; compares all outputs to the model.
    task automatic chk_now();
        int  g;
        bit  exp_wen;
        #1;
        if (m_known && !rst) begin
            g = m_grant();
            exp_wen = (g == 1) || (g == 2 && m_q[0].rd != 5'd0);
            chk("lu_ready", lu_ready, (m_q.size() < DEPTH));
            chk("fifo_count", fifo_count, m_q.size());
            chk("pipe_stall", pipe_stall, m_stall);
            chk("busy1", busy1, m_busy_rd(raddr1));
            chk("busy2", busy2, m_busy_rd(raddr2));
            chk("rf_wen", rf_wen, exp_wen);
            if (exp_wen) begin
                chk("rf_waddr", rf_waddr, (g == 1) ? pipe_waddr : m_q[0].rd);
                chk("rf_wdata", rf_wdata, (g == 1) ? pipe_wdata : m_q[0].data);
            end
        end
    endtask

    // Applies the clock edge to the model, then returns at the next negedge.
    task automatic adv();
        int g;
        bit pop;
        bit was_empty;
        bit ready;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_busy  = '0;
            m_wait  = 0;
            m_stall = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            g         = m_grant();
            pop       = (g == 2);
            was_empty = (m_q.size() == 0);
            ready     = (m_q.size() < DEPTH);
            if (pop) begin
                m_busy[m_q[0].rd] = 1'b0;
                void'(m_q.pop_front());
            end
            if (lu_valid && ready) m_q.push_back('{rd: lu_rd, data: lu_wdata});
            if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
            if (was_empty || pop) m_wait = 0;
            else if (m_wait < MAX_WAIT) m_wait++;
            m_stall = (m_wait == MAX_WAIT) && !pop;
        end
        @(negedge clk);
    endtask

    task automatic step();
        chk_now();
        adv();
    endtask

    initial begin
        clr();
        rst = 1;
        @(negedge clk);
        step();
        step();

        // Idle after reset
        clr(); raddr1 = 5'd7; raddr2 = 5'd9;
        chk_now();
        chk("rst_rf_wen", rf_wen, 1'b0);
        chk("rst_lu_ready", lu_ready, 1'b1);
        chk("rst_count", fifo_count, 0);
        adv();

        // Plain pipe write
        clr(); pipe_wen = 1; pipe_waddr = 5'd5; pipe_wdata = 64'hAA;
        chk_now();
        chk("pipe_waddr", rf_waddr, 5'd5);
        chk("pipe_wdata", rf_wdata, 64'hAA);
        adv();

        // Issue rd 7, lu result returns, busy lifetime
        clr(); issue_valid = 1; issue_rd = 5'd7; raddr1 = 5'd7; step();
        clr(); raddr1 = 5'd7;
        chk_now(); chk("busy7_set", busy1, 1'b1); adv();
        clr(); raddr1 = 5'd7; lu_valid = 1; lu_rd = 5'd7; lu_wdata = 64'h1234; step();
        clr(); raddr1 = 5'd7;
        chk_now();
        chk("lu7_waddr", rf_waddr, 5'd7);
        chk("lu7_wdata", rf_wdata, 64'h1234);
        chk("busy7_pop", busy1, 1'b1);
        adv();
        clr(); raddr1 = 5'd7;
        chk_now(); chk("busy7_clr", busy1, 1'b0); adv();

        // Continuous pipe traffic starves the FIFO until the stall fires
        clr(); pipe_wen = 1; pipe_waddr = 5'd3; pipe_wdata = 64'h33;
        lu_valid = 1; lu_rd = 5'd11; lu_wdata = 64'h11; step();
        lu_rd = 5'd12; lu_wdata = 64'h12; step();
        lu_rd = 5'd13; lu_wdata = 64'h13;
        for (int i = 0; i < 3; i++) begin
            chk_now();
            chk("full_ready", lu_ready, 1'b0);
            chk("no_stall_yet", pipe_stall, 1'b0);
            adv();
        end
        chk_now();
        chk("stall_on", pipe_stall, 1'b1);
        chk("stall_head", rf_waddr, 5'd11);
        adv();
        chk_now();
        chk("stall_off", pipe_stall, 1'b0);
        chk("after_stall_count", fifo_count, 1);
        chk("after_stall_ready", lu_ready, 1'b1);
        adv();
        clr();
        for (int i = 0; i < 3; i++) step();

        // Issue of rd 9 in the same cycle the rd-9 head pops: stays busy
        clr(); issue_valid = 1; issue_rd = 5'd9; step();
        clr(); lu_valid = 1; lu_rd = 5'd9; lu_wdata = 64'h99; step();
        clr(); issue_valid = 1; issue_rd = 5'd9; raddr1 = 5'd9;
        chk_now(); chk("pop9_waddr", rf_waddr, 5'd9); adv();
        clr(); raddr1 = 5'd9;
        chk_now(); chk("busy9_kept", busy1, 1'b1); adv();

        // rd 0 result and waddr 0 request are not writes
        clr(); lu_valid = 1; lu_rd = 5'd0; lu_wdata = 64'h5; step();
        clr();
        chk_now(); chk("rd0_nowrite", rf_wen, 1'b0); adv();
        clr(); pipe_wen = 1; pipe_waddr = 5'd0; pipe_wdata = 64'h7;
        chk_now();
        chk("wa0_nowrite", rf_wen, 1'b0);
        chk("rd0_popped", fifo_count, 0);
        adv();

        // Reset mid-operation
        clr(); pipe_wen = 1; pipe_waddr = 5'd3; lu_valid = 1; lu_rd = 5'd14;
        issue_valid = 1; issue_rd = 5'd14; step();
        lu_rd = 5'd15; issue_rd = 5'd15; step();
        clr(); pipe_wen = 1; pipe_waddr = 5'd3; raddr1 = 5'd14; raddr2 = 5'd15;
        chk_now();
        chk("pre_rst_count", fifo_count, 2);
        chk("pre_rst_busy", busy2, 1'b1);
        adv();
        clr(); rst = 1; step();
        clr(); raddr1 = 5'd14; raddr2 = 5'd15;
        chk_now();
        chk("post_rst_count", fifo_count, 0);
        chk("post_rst_busy1", busy1, 1'b0);
        chk("post_rst_busy2", busy2, 1'b0);
        chk("post_rst_stall", pipe_stall, 1'b0);
        adv();

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            clr();
            rst         = ($urandom_range(0, 149) == 0);
            pipe_wen    = ($urandom_range(0, 3) != 0);
            pipe_waddr  = 5'($urandom_range(0, 7));
            pipe_wdata  = {$urandom, $urandom};
            lu_valid    = ($urandom_range(0, 1) == 1);
            lu_rd       = 5'($urandom_range(0, 7));
            lu_wdata    = {$urandom, $urandom};
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd    = 5'($urandom_range(0, 7));
            raddr1      = 5'($urandom_range(0, 8));
            raddr2      = 5'($urandom_range(0, 8));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
